i2c_sda_delay: RTL and testbench
================================

# i2c_sda_delay

SDA conditioning stage between the SDX pad controller (`io_ctrl`) and the I2C slave core. On the input path it synchronises the raw SDA level and rejects glitches shorter than a programmable number of clocks. On the output path it delays every SDA drive change from the core by a fixed hold time before passing it to the pad controller. The output is the active-low pad output-enable that `io_ctrl` expects.

## Interface
Parameters:
- `FILT_CYC`, 4: consecutive cycles a new synchronised SDA level must persist before it is accepted. Legal range 1..15.
- `HOLD_CYC`, 6: clock cycles between sampling a core drive change and presenting it to the pad. Legal range 0..63.

Ports:
- `clk`  in  1  system clock; single clock domain. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sda_pad_i`  in  1  raw SDA level from `io_ctrl`. Asynchronous to `clk`.
- `sda_core_i`  out  1  filtered SDA level to the I2C core.
- `sda_core_o`  in  1  core drive request: 0 = pull low, 1 = release.
- `sda_pad_o`  out  1  delayed drive to `io_ctrl`: 0 = enable pad driving 0, 1 = release.
- `glitch_det`  out  1  one-cycle pulse when a rejected glitch ends.

## Operation
Input path:
- A 2-flop synchroniser `s1 -> s2` samples `sda_pad_i`.
- Filter counter `fcnt` (4 bit), evaluated each edge:
  - `s2 == sda_core_i`: `fcnt <= 0`. If `fcnt != 0` at that edge, `glitch_det <= 1`; otherwise `glitch_det <= 0`.
  - `s2 != sda_core_i` and `fcnt == FILT_CYC-1`: `sda_core_i <= s2`, `fcnt <= 0`.
  - `s2 != sda_core_i` otherwise: `fcnt <= fcnt+1`.
- Result: a level seen at `s2` for fewer than `FILT_CYC` consecutive edges never reaches the core.

Output path, a two-state FSM:
- IDLE:
  - If `sda_core_o != sda_pad_o`: with `HOLD_CYC == 0`, `sda_pad_o <= sda_core_o` and stay in IDLE.
  - Otherwise load `pend <= sda_core_o` and `hcnt <= HOLD_CYC`, then go to HOLD.
- HOLD, in priority order:
  - `sda_core_o == sda_pad_o` (request reverted): cancel and go to IDLE. `sda_pad_o` is unchanged.
  - `sda_core_o != pend` cannot occur (1-bit signal, so a mismatch means reverted). Covered by the rule above.
  - `hcnt == 1`: `sda_pad_o <= pend`, go to IDLE.
  - Otherwise `hcnt <= hcnt-1`.
- `hcnt` is 6 bits. It never wraps: it is only decremented when greater than 1.

Reset:
- `s1`, `s2`, `sda_core_i`, `sda_pad_o` = 1 (bus released).
- `fcnt` = 0, `hcnt` = 0, `pend` = 1, `glitch_det` = 0, FSM = IDLE.
- Reset asserted mid-filter or mid-HOLD discards all pending state. `sda_pad_o` is released at the same edge.

## Timing
- Input latency:
  - `sda_pad_i` is stable before edge k. It is in `s2` after edge k+1.
  - `sda_core_i` changes after edge k+1+`FILT_CYC` (6 edges for the default).
- Output latency:
  - `sda_core_o` changes before edge k. `sda_pad_o` changes after edge k+`HOLD_CYC`.
  - With `HOLD_CYC` = 0 the change appears after edge k (registered, 1 cycle).
- `glitch_det` is high for exactly the one cycle after the edge at which the glitch run ends.
- Input and output paths are independent. Simultaneous events on both paths are handled in the same cycle without interaction.
- No combinational path from any input to any output.

## Structure
- Package `i2c_io_pkg` holds:
  - default `FILT_CYC` / `HOLD_CYC` constants;
  - the `FCNT_W` = 4 and `HCNT_W` = 6 widths;
  - the FSM state enum `{IDLE, HOLD}`.
- Sub-module `i2c_glitch_filter`: synchroniser, filter counter and `glitch_det`. It is reused later for SCL.
- The top level instantiates the sub-module and implements the hold-delay FSM.

## Test plan
- Reset with `sda_pad_i`=0 and `sda_core_o`=0:
  - during reset, `sda_core_i`=1 and `sda_pad_o`=1;
  - after release, `sda_pad_o` falls after edge 6 (`HOLD_CYC`=6) and `sda_core_i` falls after edge 5.
- 1→0 step on `sda_pad_i` before edge 10 (default params) -> `sda_core_i`=0 after edge 15, `glitch_det` stays 0.
- 3-cycle low pulse on `sda_pad_i` -> `sda_core_i` stays 1, and `glitch_det` pulses once, 1 cycle wide.
- `sda_core_o` 1→0 before edge 20 -> `sda_pad_o`=0 after edge 26. Then `sda_core_o` 0→1 before edge 30 -> `sda_pad_o`=1 after edge 36.
- `sda_core_o` low for 3 cycles, then back to 1 -> HOLD cancelled, `sda_pad_o` never leaves 1. Repeat with `HOLD_CYC`=0 -> `sda_pad_o` follows with 1-cycle delay.
- `rst` asserted 2 cycles into HOLD and mid-filter -> next edge: `sda_pad_o`=1, FSM IDLE, `fcnt`=0. Post-reset behaviour matches a fresh start.

Source files
------------

// File: rtl/i2c_io_pkg.sv
// Shared constants and types for the I2C pad conditioning blocks.
package i2c_io_pkg;

    localparam int unsigned FILT_CYC_DEF = 4;
    localparam int unsigned HOLD_CYC_DEF = 6;

    localparam int unsigned FCNT_W = 4;
    localparam int unsigned HCNT_W = 6;

    typedef enum logic {
        IDLE,
        HOLD
    } hold_state_e;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser plus persistence filter; a new level is accepted only after it has
// been stable for FILT_CYC edges. Rejected runs raise a one-cycle glitch pulse.
module i2c_glitch_filter
    import i2c_io_pkg::*;
#(
    parameter int unsigned FILT_CYC = FILT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic lvl_o,
    output logic glitch_o
);

    localparam logic [FCNT_W-1:0] FcntLast = FCNT_W'(FILT_CYC - 1);

    logic              s1_q;
    logic              s2_q;
    logic              lvl_q;
    logic              lvl_d;
    logic              glitch_q;
    logic              glitch_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;

    always_comb begin
        fcnt_d   = fcnt_q;
        lvl_d    = lvl_q;
        glitch_d = 1'b0;
        if (s2_q == lvl_q) begin
            // A nonzero count here means a run ended before it was long enough.
            fcnt_d   = '0;
            glitch_d = (fcnt_q != '0);
        end else if (fcnt_q == FcntLast) begin
            lvl_d  = s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            lvl_q    <= 1'b1;
            glitch_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            s1_q     <= lvl_i;
            s2_q     <= s1_q;
            lvl_q    <= lvl_d;
            glitch_q <= glitch_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign lvl_o    = lvl_q;
    assign glitch_o = glitch_q;

endmodule

// File: rtl/i2c_sda_delay.sv
// SDA conditioning between the pad controller and the I2C core: filtered input path and a
// hold-time delayed, cancellable output drive path.
module i2c_sda_delay
    import i2c_io_pkg::*;
#(
    parameter int unsigned FILT_CYC = FILT_CYC_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sda_pad_i,
    output logic sda_core_i,
    input  logic sda_core_o,
    output logic sda_pad_o,
    output logic glitch_det
);

    localparam logic [HCNT_W-1:0] HcntLoad = HCNT_W'(HOLD_CYC);

    i2c_glitch_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .lvl_i    (sda_pad_i),
        .lvl_o    (sda_core_i),
        .glitch_o (glitch_det)
    );

    hold_state_e       state_q;
    hold_state_e       state_d;
    logic [HCNT_W-1:0] hcnt_q;
    logic [HCNT_W-1:0] hcnt_d;
    logic              pend_q;
    logic              pend_d;
    logic              pad_q;
    logic              pad_d;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        pend_d  = pend_q;
        pad_d   = pad_q;
        unique case (state_q)
            IDLE: begin
                if (sda_core_o != pad_q) begin
                    if (HOLD_CYC == 0) begin
                        pad_d = sda_core_o;
                    end else begin
                        pend_d  = sda_core_o;
                        hcnt_d  = HcntLoad;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // On a 1-bit request, matching the pad again means the change was withdrawn.
                if (sda_core_o == pad_q) begin
                    state_d = IDLE;
                end else if (hcnt_q == HCNT_W'(1)) begin
                    pad_d   = pend_q;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            pend_q  <= 1'b1;
            pad_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pend_q  <= pend_d;
            pad_q   <= pad_d;
        end
    end

    assign sda_pad_o = pad_q;

endmodule

// File: tb/tb_i2c_sda_delay.sv
// Bench for i2c_sda_delay: default-parameter and minimum-parameter instances driven in
// parallel, compared every cycle against a window/run-length reference model.
module tb_i2c_sda_delay;

    localparam int unsigned FA = 4;
    localparam int unsigned HA = 6;
    localparam int unsigned FB = 1;
    localparam int unsigned HB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pad_in;
    logic core_out;
    logic core_in_a, pad_out_a, glitch_a;
    logic core_in_b, pad_out_b, glitch_b;

    i2c_sda_delay #(
        .FILT_CYC (FA),
        .HOLD_CYC (HA)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .sda_pad_i  (pad_in),
        .sda_core_i (core_in_a),
        .sda_core_o (core_out),
        .sda_pad_o  (pad_out_a),
        .glitch_det (glitch_a)
    );

    i2c_sda_delay #(
        .FILT_CYC (FB),
        .HOLD_CYC (HB)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .sda_pad_i  (pad_in),
        .sda_core_i (core_in_b),
        .sda_core_o (core_out),
        .sda_pad_o  (pad_out_b),
        .glitch_det (glitch_b)
    );

    // Reference model state
    logic        m_s1, m_s2;
    logic [15:0] hist_a, hist_b;
    logic        m_core_a, m_core_b, m_gl_a, m_gl_b, m_pad_a, m_pad_b;
    int          run_a, run_b;
    int          n_checks = 0;
    int          n_fail = 0;
    int          gl_seen_a = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1;
        hist_a = '1; hist_b = '1;
        m_core_a = 1'b1; m_core_b = 1'b1;
        m_gl_a = 1'b0; m_gl_b = 1'b0;
        m_pad_a = 1'b1; m_pad_b = 1'b1;
        run_a = 0; run_b = 0;
    endtask

    // Accept a level once the last `filt` synchronised samples all disagree with the output.
    task automatic filt_model(input int unsigned filt, input logic s2_now,
                              inout logic [15:0] hist, inout logic core, output logic glitch);
        bit all_diff;
        hist   = {hist[14:0], s2_now};
        glitch = (hist[0] == core) && (hist[1] != core);
        all_diff = 1'b1;
        for (int i = 0; i < int'(filt); i++) if (hist[i] == core) all_diff = 1'b0;
        if (all_diff) core = ~core;
    endtask

    // The pad takes the request once it has disagreed for hold+1 consecutive edges.
    task automatic hold_model(input int unsigned hold, input logic req,
                              inout logic pad, inout int run);
        if (req != pad) begin
            run++;
            if (run == int'(hold) + 1) begin
                pad = req;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            filt_model(FA, m_s2, hist_a, m_core_a, m_gl_a);
            filt_model(FB, m_s2, hist_b, m_core_b, m_gl_b);
            hold_model(HA, core_out, m_pad_a, run_a);
            hold_model(HB, core_out, m_pad_b, run_b);
            m_s2 = m_s1;
            m_s1 = pad_in;
        end
        @(negedge clk);
        check("core_in_a", core_in_a, m_core_a);
        check("glitch_a",  glitch_a,  m_gl_a);
        check("pad_out_a", pad_out_a, m_pad_a);
        check("core_in_b", core_in_b, m_core_b);
        check("glitch_b",  glitch_b,  m_gl_b);
        check("pad_out_b", pad_out_b, m_pad_b);
        if (glitch_a === 1'b1) gl_seen_a++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        rst = 1'b1; pad_in = 1'b0; core_out = 1'b0;

        // Reset with both paths requesting low; outputs stay released.
        run(3);
        rst = 1'b0;
        run(12);

        // Return to idle-high bus.
        pad_in = 1'b1; core_out = 1'b1;
        run(12);

        // Clean falling step on the pad.
        pad_in = 1'b0;
        run(10);
        pad_in = 1'b1;
        run(10);

        // Three-cycle low pulse must be rejected with a single glitch pulse.
        gl_seen_a = 0;
        pad_in = 1'b0;
        run(3);
        pad_in = 1'b1;
        run(10);
        check("glitch_pulse_count", gl_seen_a[0], 1'b1);
        check("glitch_pulse_single", (gl_seen_a == 1), 1'b1);

        // Core drive low then release, each held long enough.
        core_out = 1'b0;
        run(10);
        core_out = 1'b1;
        run(10);

        // Short low request is cancelled on the delayed instance.
        core_out = 1'b0;
        run(3);
        core_out = 1'b1;
        run(10);

        // Reset mid-HOLD and mid-filter, then behave like a fresh start.
        core_out = 1'b0; pad_in = 1'b0;
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(15);
        core_out = 1'b1; pad_in = 1'b1;
        run(12);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) pad_in = ~pad_in;
            if ($urandom_range(7) == 0) core_out = ~core_out;
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
